// File: rtl/alu_mc_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [2:0] OP_SUB   = 3'b000;
    localparam logic [2:0] OP_NAND  = 3'b001;
    localparam logic [2:0] OP_LONES = 3'b010;
    localparam logic [2:0] OP_OHDEC = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;

    localparam int FLG_ERR = 0;
    localparam int FLG_NEG = 1;
    localparam int FLG_POS = 2;
    localparam int FLG_OVF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine: shift-add signed multiplier and (with ALU_MC_DIV_EN) restoring
// unsigned divider sharing one accumulator/shift register pair and iteration counter.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
`ifdef ALU_MC_DIV_EN
    input  logic             i_div,
`endif
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   sh_q, sh_d, opnd_q;
    logic               neg_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mag, prod;
    logic               ovf;
`ifdef ALU_MC_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     rem_sh;
`endif

    // Results are taken from the next-state values so the last step and capture share an edge.
    always_comb begin
        sum  = hi_q + {1'b0, (sh_q[0] ? opnd_q : {WIDTH{1'b0}})};
        hi_d = {1'b0, sum[WIDTH:1]};
        sh_d = {sum[0], sh_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        rem_sh = {hi_q[WIDTH-1:0], sh_q[WIDTH-1]};
        if (div_q) begin
            if (rem_sh >= {1'b0, opnd_q}) begin
                hi_d = rem_sh - {1'b0, opnd_q};
                sh_d = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh;
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
        mag  = {hi_d[WIDTH-1:0], sh_d};
        prod = neg_q ? -mag : mag;
        ovf  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
    end

    assign o_last = (cnt_q == LAST);
`ifdef ALU_MC_DIV_EN
    assign o_result = div_q ? sh_d : prod[WIDTH-1:0];
    assign o_ovf    = ~div_q & ovf;
`else
    assign o_result = prod[WIDTH-1:0];
    assign o_ovf    = ovf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (i_start) begin
            cnt_q <= '0;
            hi_q  <= '0;
`ifdef ALU_MC_DIV_EN
            div_q <= i_div;
            if (i_div) begin
                sh_q   <= i_arg0;
                opnd_q <= i_arg1;
                neg_q  <= 1'b0;
            end else
`endif
            begin
                sh_q   <= i_arg0[WIDTH-1] ? -i_arg0 : i_arg0;
                opnd_q <= i_arg1[WIDTH-1] ? -i_arg1 : i_arg1;
                neg_q  <= i_arg0[WIDTH-1] ^ i_arg1[WIDTH-1];
            end
        end else if (i_step) begin
            cnt_q <= o_last ? '0 : cnt_q + CW'(1);
            hi_q  <= hi_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: IDLE/BUSY/DONE FSM, single-cycle ops and flag generation.
// ALU_MC_DIV_EN enables the iterative divider; otherwise opcode 101 is illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_oper,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flag,
    output state_e           o_state
);

    state_e           state_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flag_q;

    logic [WIDTH-1:0] sc_res, lones, oh_idx;
    logic             sc_err, sc_ovf, is_iter, run, onehot;
    logic             it_start, it_last, it_ovf;
    logic [WIDTH-1:0] it_res;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic err,
                                            input logic ovf);
        logic nz;
        nz = |r;
        mk_flags = '0;
        mk_flags[FLG_ERR] = err;
        mk_flags[FLG_NEG] = r[WIDTH-1] & nz;
        mk_flags[FLG_POS] = ~r[WIDTH-1] & nz;
        mk_flags[FLG_OVF] = ovf;
    endfunction

    always_comb begin
        lones  = '0;
        run    = 1'b1;
        oh_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (run && i_arg0[i]) lones = lones + WIDTH'(1);
            else                  run = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (i_arg0[i]) oh_idx = WIDTH'(i);
        end
        onehot = (i_arg0 != '0) && ((i_arg0 & (i_arg0 - WIDTH'(1))) == '0);
    end

    always_comb begin
        sc_res  = '0;
        sc_err  = 1'b0;
        sc_ovf  = 1'b0;
        is_iter = 1'b0;
        case (i_oper)
            OP_SUB: begin
                sc_res = i_arg0 - i_arg1;
                sc_ovf = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != i_arg0[WIDTH-1]);
            end
            OP_NAND:  sc_res = ~(i_arg0 & i_arg1);
            OP_LONES: sc_res = lones;
            OP_OHDEC: begin
                if (onehot) sc_res = oh_idx;
                else        sc_err = 1'b1;
            end
            OP_MUL:   is_iter = 1'b1;
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                if (i_arg1 == '0) sc_err  = 1'b1;
                else              is_iter = 1'b1;
            end
`endif
            default:  sc_err = 1'b1;
        endcase
    end

    assign it_start = (state_q == ST_IDLE) & i_valid & is_iter;

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (it_start),
`ifdef ALU_MC_DIV_EN
        .i_div    (i_oper == OP_DIV),
`endif
        .i_step   (state_q == ST_BUSY),
        .i_arg0   (i_arg0),
        .i_arg1   (i_arg1),
        .o_last   (it_last),
        .o_result (it_res),
        .o_ovf    (it_ovf)
    );

    // Outside reset, accept reduces to i_valid in IDLE since o_ready is just IDLE & ~i_rst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            flag_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (is_iter) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q  <= ST_DONE;
                            valid_q  <= 1'b1;
                            result_q <= sc_res;
                            flag_q   <= mk_flags(sc_res, sc_err, sc_ovf);
                        end
                    end
                end
                ST_BUSY: begin
                    if (it_last) begin
                        state_q  <= ST_DONE;
                        valid_q  <= 1'b1;
                        result_q <= it_res;
                        flag_q   <= mk_flags(it_res, 1'b0, it_ovf);
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready  = (state_q == ST_IDLE) & ~i_rst;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_flag   = flag_q;
    assign o_state  = state_q;

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor of the registered 4-op ALU. Accepts one operation at a time through a valid/ready handshake and executes single-cycle ops (SUB, NAND, leading-ones, one-hot decode) and iterative ops (signed MUL, unsigned DIV) on a shared FSM. It delivers a registered result and 4-bit flag word through a held output handshake. It sits between the operand sequencer and the result writeback stage.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..32
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  operation request
- o_ready  out  1  block can accept a request
- i_oper  in  3  opcode
- i_arg0  in  WIDTH  operand A, signed
- i_arg1  in  WIDTH  operand B, signed
- o_valid  out  1  result/flags valid
- i_ready  in  1  consumer accepts result
- o_result  out  WIDTH  result, signed
- o_flag  out  4  [0] err, [1] neg, [2] pos, [3] overflow

## Operation
- FSM states: IDLE, BUSY, DONE. Accept = i_valid & o_ready; operands and opcode are registered at accept. Later input changes are ignored.
- o_ready = (state == IDLE) & ~i_rst.
- Opcodes:
  - 000 SUB: A−B mod 2^WIDTH; overflow = signed overflow.
  - 001 NAND: ~(A&B).
  - 010 LONES: count of consecutive 1s in A starting from the MSB (0..WIDTH); B ignored.
  - 011 OHDEC: index of the single set bit of A. If A is not one-hot: err=1, result 0. B ignored.
  - 100 MUL: signed. Magnitudes multiplied by shift-add, one bit per cycle over WIDTH cycles. The 2·WIDTH product is negated if the signs differ. Result = low WIDTH bits; overflow = product outside the signed WIDTH range.
  - 101 DIV: unsigned restoring division, one quotient bit per cycle over WIDTH cycles; result = quotient. If B==0: err=1, result 0, no iteration.
  - 110, 111: err=1, result 0.
- neg = result MSB & (result≠0); pos = ~MSB & (result≠0). Both are computed from the final result for every opcode, DIV included. Overflow is 0 except for SUB and MUL. err is 0 except where stated.
- IDLE→DONE on accept of a single-cycle op or DIV by zero. IDLE→BUSY on accept of MUL or DIV. BUSY→DONE when the iteration counter reaches WIDTH−1. DONE→IDLE when i_ready is high.
- o_result and o_flag are registered and hold stable throughout DONE.

## Timing
- Reset values: state IDLE, o_valid 0, o_result 0, o_flag 0, iteration counter 0.
- Single-cycle ops: accept at cycle N, o_valid at N+1.
- MUL/DIV: accept at N, o_valid at N+WIDTH+1.
- Backpressure: o_valid, o_result and o_flag hold unchanged until i_ready. Handshake at cycle M gives o_valid=0 and o_ready=1 at M+1. Maximum throughput is one op per 2 cycles; no overlap.
- i_rst during BUSY or DONE: the in-flight op is discarded and all outputs take reset values on the next edge. i_rst has priority over i_valid in the same cycle.
- i_ready while o_valid=0 has no effect.

## Configuration
- ALU_MC_DIV_EN defined: DIV datapath built as specified.
- Not defined: no divider logic. Opcode 101 behaves as an illegal opcode (single cycle, err=1, result 0).

## Structure
- Package alu_mc_pkg holds:
  - opcode localparams (OP_SUB … OP_DIV)
  - flag bit indices (FLG_ERR, FLG_NEG, FLG_POS, FLG_OVF)
  - FSM state encoding
- Sub-module alu_mc_iter: shift-add multiplier and restoring divider sharing one accumulator/shift register and iteration counter, started and stopped by the top FSM. Single-cycle ops stay in the top module.

## Test plan
- WIDTH=8 SUB, A=−128, B=1 → result 127, flags 4'b1100, o_valid one cycle after accept.
- MUL −7×6 → result −42 (0xD6), flags 4'b0010, o_valid 9 cycles after accept. MUL 12×−11 → result 0x7C, flags 4'b1100.
- DIV 200/7 (A=0xC8) → result 28, flags 4'b0100 after 9 cycles. DIV by 0 → result 0, flags 4'b0001 after 1 cycle. Without ALU_MC_DIV_EN, opcode 101 → flags 4'b0001 after 1 cycle.
- OHDEC A=0x10 → result 4, flags 4'b0100. OHDEC A=0x12 → result 0, flags 4'b0001. LONES A=0xE5 → result 3.
- Backpressure: hold i_ready low 5 cycles in DONE → o_valid, o_result, o_flag stable and o_ready low throughout. Release → o_ready high next cycle.
- Assert i_rst at the 4th BUSY cycle of a MUL → next edge all outputs 0 and state IDLE. A new SUB accepted after reset completes correctly.
